// File: rtl/cache_l1_param.sv
`default_nettype none
// ============================================================================
// Module      : cache_l1_param
// Description : Direct-mapped, write-through, no-write-allocate L1 data cache
//               with request handshake, registered response and acked memory
//               port. Optional hit/miss counters under CACHE_L1_STATS_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module cache_l1_param #(
    parameter int ADDR_W  = 10,
    parameter int INDEX_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_mask,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
`ifdef CACHE_L1_STATS_EN
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
`endif
    input  logic [31:0]       mem_rdata
);

    localparam int C_LINES = 2 ** INDEX_W;
    localparam int C_TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [C_LINES-1:0]    r_valid;
    logic [C_TAG_W-1:0]    r_tag  [C_LINES];
    logic [31:0]           r_data [C_LINES];
    logic [2:0]            r_mask;
    logic [ADDR_W-1:0]     r_addr;
    logic [3:0]            r_be;
    logic [31:0]           r_lane_data;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;

    logic [INDEX_W-1:0]    w_idx;
    logic [INDEX_W-1:0]    w_fill_idx;
    logic [C_TAG_W-1:0]    w_tag;
    logic                  w_hit;
    logic                  w_accept;
    logic                  w_store_legal;
    logic                  w_load_legal;
    logic                  w_fill;
    logic [3:0]            w_be;
    logic [31:0]           w_lane_data;
    logic [31:0]           w_merged;

    function automatic logic [31:0] f_extract(input logic [31:0] data_word,
                                              input logic [2:0]  mask,
                                              input logic [1:0]  off);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        shifted = data_word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? data_word[31:16] : data_word[15:0];
        case (mask)
            3'b000:  result = {{24{b[7]}}, b};
            3'b001:  result = {{16{h[15]}}, h};
            3'b010:  result = data_word;
            3'b100:  result = {24'd0, b};
            3'b101:  result = {16'd0, h};
            default: result = 32'd0;
        endcase
        return result;
    endfunction

    assign w_idx         = req_addr[INDEX_W+1:2];
    assign w_tag         = req_addr[ADDR_W-1:INDEX_W+2];
    assign w_fill_idx    = r_addr[INDEX_W+1:2];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_accept      = req_valid && req_ready;
    assign w_fill        = (r_state == RD_MISS) && mem_ack;
    assign w_store_legal = (req_mask == 3'b000) || (req_mask == 3'b001) || (req_mask == 3'b010);
    assign w_load_legal  = w_store_legal || (req_mask == 3'b100) || (req_mask == 3'b101);

    // Store byte enables and lane-replicated data, derived from the live request.
    always_comb begin
        w_be        = 4'b0000;
        w_lane_data = req_wdata;
        case (req_mask)
            3'b000: begin
                w_be        = 4'b0001 << req_addr[1:0];
                w_lane_data = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{req_wdata[15:0]}};
            end
            3'b010:  w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge_byte
        assign w_merged[8*gi +: 8] = w_be[gi] ? w_lane_data[8*gi +: 8]
                                              : r_data[w_idx][8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = (r_state == IDLE) && !flush && !reset;
        mem_rd_en    = (r_state == RD_MISS);
        mem_wr_en    = (r_state == WR_THRU);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_we) begin
                        w_next_state = w_store_legal ? WR_THRU : IDLE;
                    end else if (w_load_legal && !w_hit) begin
                        w_next_state = RD_MISS;
                    end
                end
            end
            RD_MISS: if (mem_ack) w_next_state = RESP;
            WR_THRU: if (mem_ack) w_next_state = IDLE;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= '0;
            r_mask      <= 3'd0;
            r_addr      <= '0;
            r_be        <= 4'd0;
            r_lane_data <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            if ((r_state == IDLE) && flush) begin
                r_valid <= '0;
            end
            if (w_accept) begin
                r_mask      <= req_mask;
                r_addr      <= req_addr;
                r_be        <= (req_we && w_store_legal) ? w_be : 4'd0;
                r_lane_data <= (req_we && w_store_legal) ? w_lane_data : 32'd0;
                if (!req_we && (!w_load_legal || w_hit)) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_load_legal
                                 ? f_extract(r_data[w_idx], req_mask, req_addr[1:0])
                                 : 32'd0;
                end
            end
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
                r_rsp_valid         <= 1'b1;
                r_rsp_rdata         <= f_extract(mem_rdata, r_mask, r_addr[1:0]);
            end
        end
    end

    // Line storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_accept && req_we && w_store_legal && w_hit) begin
                r_data[w_idx] <= w_merged;
            end
            if (w_fill) begin
                r_tag[w_fill_idx]  <= r_addr[ADDR_W-1:INDEX_W+2];
                r_data[w_fill_idx] <= mem_rdata;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_addr  = r_addr[ADDR_W-1:2];
    assign mem_be    = r_be;
    assign mem_wdata = r_lane_data;

`ifdef CACHE_L1_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
        end else if (w_accept && !req_we && w_load_legal) begin
            if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (!w_hit && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_l1_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_l1_param
// Description : Directed and random checks of cache_l1_param against a
//               memory-image reference model and an acking memory responder.
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_cache_l1_param;

    localparam int LINES = 64;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_mask;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef CACHE_L1_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int          total   = 0;
    int          bad     = 0;
    int          mem_lat = 0;
    int          exp_hit = 0;
    int          exp_miss = 0;
    logic [31:0] ref_mem [0:255];
    logic        cvalid  [0:LINES-1];
    int          ctag    [0:LINES-1];

    cache_l1_param #(.ADDR_W(10), .INDEX_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_mask  (req_mask),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
`ifdef CACHE_L1_STATS_EN
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
`endif
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
        $fatal(1, "watchdog expired");
    end

    // Memory responder: acks after mem_lat further cycles of a held enable.
    initial begin
        int rcnt;
        rcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!(mem_rd_en || mem_wr_en)) begin
                rcnt = 0;
            end else begin
                rcnt++;
                if (rcnt > mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_rd_en ? ref_mem[mem_addr] : $urandom;
                    rcnt      = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] mask, input logic [9:0] addr);
        logic [31:0] w;
        logic [31:0] v;
        int          off;
        w   = ref_mem[addr / 4];
        off = int'(addr % 4);
        v   = 32'd0;
        if (mask == 3'b000 || mask == 3'b100) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (mask == 3'b000 && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (mask == 3'b001 || mask == 3'b101) begin
            v = (w >> (8 * (off & 2))) & 32'hFFFF;
            if (mask == 3'b001 && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else if (mask == 3'b010) begin
            v = w;
        end
        return v;
    endfunction

    task automatic issue(input logic we, input logic [2:0] mask, input logic [9:0] addr,
                         input logic [31:0] wd);
        logic acc;
        int   waitc;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_mask  = mask;
        req_addr  = addr;
        req_wdata = wd;
        acc       = 1'b0;
        waitc     = 0;
        while (!acc && waitc < 40) begin
            #1 acc = req_ready;
            @(posedge clk);
            waitc++;
        end
        #1 req_valid = 1'b0;
        check("accept", acc, 1);
    endtask

    task automatic do_load(input logic [2:0] mask, input logic [9:0] addr, input int lat);
        int          idx;
        int          tg;
        int          cyc;
        logic        legal;
        logic        exp_miss_now;
        logic        saw_rd;
        logic        saw_wr;
        logic [31:0] exp;
        idx          = int'((addr / 4) % LINES);
        tg           = int'(addr / 256);
        legal        = mask inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        exp_miss_now = legal && !(cvalid[idx] && ctag[idx] == tg);
        exp          = legal ? ref_load(mask, addr) : 32'd0;
        mem_lat      = lat;
        issue(1'b0, mask, addr, 32'd0);
        saw_rd = 1'b0;
        saw_wr = 1'b0;
        cyc    = 1;
        while (!rsp_valid && cyc < 40) begin
            saw_rd |= mem_rd_en;
            saw_wr |= mem_wr_en;
            @(posedge clk);
            #1 cyc++;
        end
        saw_rd |= mem_rd_en;
        saw_wr |= mem_wr_en;
        check("ld_rsp_valid", rsp_valid, 1);
        check("ld_rdata", rsp_rdata, exp);
        check("ld_miss_seen", saw_rd, exp_miss_now);
        check("ld_no_write", saw_wr, 0);
        check("ld_latency", cyc, exp_miss_now ? lat + 2 : 1);
        if (exp_miss_now) begin
            cvalid[idx] = 1'b1;
            ctag[idx]   = tg;
            exp_miss++;
        end else if (legal) begin
            exp_hit++;
        end
        cyc = 0;
        while (!req_ready && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("ld_ready_back", req_ready, 1);
    endtask

    task automatic do_store(input logic [2:0] mask, input logic [9:0] addr,
                            input logic [31:0] data, input int lat);
        logic        legal;
        int          off;
        int          size;
        int          base;
        int          cyc;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic        first_wr;
        logic [3:0]  first_be;
        logic [31:0] first_wd;
        logic [7:0]  first_addr;
        logic        saw_rd;
        logic [31:0] w;
        legal  = mask inside {3'b000, 3'b001, 3'b010};
        off    = int'(addr % 4);
        exp_be = 4'hF;
        exp_wd = data;
        if (mask == 3'b000) begin
            exp_be = 4'(1 << off);
            exp_wd = (data & 32'hFF) * 32'h0101_0101;
        end else if (mask == 3'b001) begin
            exp_be = (off >= 2) ? 4'hC : 4'h3;
            exp_wd = (data & 32'hFFFF) * 32'h0001_0001;
        end
        mem_lat = lat;
        issue(1'b1, mask, addr, data);
        first_wr   = mem_wr_en;
        first_be   = mem_be;
        first_wd   = mem_wdata;
        first_addr = mem_addr;
        saw_rd     = 1'b0;
        cyc        = 1;
        while (!req_ready && cyc < 40) begin
            saw_rd |= mem_rd_en;
            @(posedge clk);
            #1 cyc++;
        end
        check("st_wr_en", first_wr, legal);
        check("st_no_read", saw_rd, 0);
        check("st_latency", cyc, legal ? lat + 2 : 1);
        if (legal) begin
            check("st_be", first_be, exp_be);
            check("st_wdata", first_wd, exp_wd);
            check("st_addr", first_addr, addr / 4);
            size = 1 << mask;
            base = off - (off % size);
            w    = ref_mem[addr / 4];
            for (int b = 0; b < size; b++) begin
                w[8*(base+b) +: 8] = data[8*b +: 8];
            end
            ref_mem[addr / 4] = w;
        end
    endtask

    task automatic do_flush(input logic [9:0] addr);
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_mask  = 3'b010;
        req_addr  = addr;
        #1 check("flush_ready_low", req_ready, 0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        for (int k = 0; k < LINES; k++) cvalid[k] = 1'b0;
    endtask

    initial begin
        int cnt;
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_mask  = 3'b000;
        req_addr  = 10'd0;
        req_wdata = 32'd0;
        for (int k = 0; k < 256; k++) ref_mem[k] = $urandom;
        for (int k = 0; k < LINES; k++) begin
            cvalid[k] = 1'b0;
            ctag[k]   = 0;
        end
        ref_mem[10'h104 / 4] = 32'h8081_F0F1;

        repeat (3) @(posedge clk);
        #1 check("ready_in_reset", req_ready, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);

        // Miss then hit.
        do_load(3'b010, 10'h104, 3);
        check("tp_lw_fill", rsp_rdata, 32'h8081_F0F1);
        do_load(3'b000, 10'h107, 0);
        check("tp_lb_hit", rsp_rdata, 32'hFFFF_FF80);

        // Store hit merge.
        do_store(3'b001, 10'h106, 32'h0000_1234, 1);
        do_load(3'b010, 10'h104, 0);
        check("tp_merge", rsp_rdata, 32'h1234_F0F1);

        // Store miss leaves the cache untouched.
        do_store(3'b000, 10'h3F1, 32'h0000_00AB, 0);
        do_load(3'b100, 10'h3F1, 2);
        check("tp_lbu_after_sb", rsp_rdata, 32'h0000_00AB);

        // Conflict on the same index.
        do_load(3'b010, 10'h004, 1);
        do_load(3'b010, 10'h104, 0);
        do_load(3'b010, 10'h004, 2);

        // Flush then a miss.
        do_flush(10'h004);
        do_load(3'b010, 10'h004, 0);

        // Illegal load mask.
        do_load(3'b011, 10'h004, 0);
        check("tp_illegal_zero", rsp_rdata, 0);

`ifdef CACHE_L1_STATS_EN
        check("stats_hit", hit_cnt, exp_hit);
        check("stats_miss", miss_cnt, exp_miss);
`endif

        // Reset during a miss, with the ack landing in the reset cycle.
        mem_lat = 2;
        issue(1'b0, 3'b010, 10'h208, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rm_rd_before_reset", mem_rd_en, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rm_rd_dropped", mem_rd_en, 0);
        check("rm_no_rsp", rsp_valid, 0);
        check("rm_ready_in_reset", req_ready, 0);
        reset = 1'b0;
        for (int k = 0; k < LINES; k++) cvalid[k] = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1 if (rsp_valid || mem_rd_en) cnt++;
        end
        check("rm_quiet_after_reset", cnt, 0);
        do_load(3'b010, 10'h208, 0);

        // Random mix.
        for (int i = 0; i < 300; i++) begin
            int unsigned sel;
            logic [9:0]  a;
            logic [2:0]  m;
            sel = $urandom_range(0, 99);
            a   = 10'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2)
                      | $urandom_range(0, 3));
            m   = 3'($urandom_range(0, 7));
            if (sel < 5) begin
                do_flush(a);
            end else if (sel < 35) begin
                do_store(m, a, $urandom, int'($urandom_range(0, 3)));
            end else begin
                do_load(m, a, int'($urandom_range(0, 3)));
            end
        end

`ifdef CACHE_L1_STATS_EN
        check("stats_hit_final", hit_cnt, exp_hit);
        check("stats_miss_final", miss_cnt, exp_miss);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
